// File: rtl/credential_entry_if.sv
// Signal bundle between the button front end and its surroundings:
// raw buttons and verifier result in, edited credentials and status out.
interface credential_entry_if;
   logic        left_button;
   logic        right_button;
   logic        up_button;
   logic        down_button;
   logic        center_button;
   logic        valid;
   logic [63:0] username;
   logic [63:0] password;
   logic [2:0]  cursor;
   logic [3:0]  fail_count;
   logic [3:0]  leds;

   modport master (
      output left_button, right_button, up_button, down_button, center_button, valid,
      input  username, password, cursor, fail_count, leds
   );

   modport slave (
      input  left_button, right_button, up_button, down_button, center_button, valid,
      output username, password, cursor, fail_count, leds
   );
endinterface

// File: rtl/credential_entry.sv
// Debounced five-button credential editor: edits an 8-char username and password,
// submits them to the verifier and runs the grant/deny/lockout sequence.
module credential_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned MAX_FAILS       = 3,
   parameter int unsigned LOCKOUT_CYCLES  = 500_000_000
) (
   input logic              clk_100,
   input logic              rst_n,
   credential_entry_if.slave bus
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [63:0] BLANK = {8{8'h20}};

   typedef enum logic [2:0] {USER, PASS, CHECK, GRANTED, DENIED, LOCKED} state_t;

   // Button bit order doubles as the action priority: center, up, down, left, right.
   logic [4:0]      raw;
   logic [4:0]      sync_a;
   logic [4:0]      sync_b;
   logic [4:0]      level;
   logic [4:0]      press;
   logic [DB_W-1:0] db_cnt [5];

   state_t          state;
   logic [63:0]     user_q;
   logic [63:0]     pass_q;
   logic [2:0]      cursor_q;
   logic [3:0]      fail_q;
   logic [3:0]      leds_q;
   logic [LK_W-1:0] lock_cnt;
   logic [5:0]      sel_lsb;
   logic [7:0]      user_char;
   logic [7:0]      pass_char;

   function automatic logic [7:0] char_up(input logic [7:0] c);
      return (c == 8'h7E) ? 8'h20 : c + 8'd1;
   endfunction

   function automatic logic [7:0] char_down(input logic [7:0] c);
      return (c == 8'h20) ? 8'h7E : c - 8'd1;
   endfunction

   assign raw = {bus.center_button, bus.up_button, bus.down_button,
                 bus.left_button, bus.right_button};

   // Char 0 lives in the top byte, so the byte offset is the inverted cursor.
   assign sel_lsb   = {~cursor_q, 3'b000};
   assign user_char = user_q[sel_lsb +: 8];
   assign pass_char = pass_q[sel_lsb +: 8];

   always_ff @(posedge clk_100) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
         level  <= '0;
         press  <= '0;
         for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         press  <= '0;
         for (int i = 0; i < 5; i++) begin
            if (sync_b[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               db_cnt[i] <= '0;
               level[i]  <= sync_b[i];
               press[i]  <= sync_b[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_100) begin
      if (!rst_n) begin
         state    <= USER;
         user_q   <= BLANK;
         pass_q   <= BLANK;
         cursor_q <= '0;
         fail_q   <= '0;
         leds_q   <= '0;
         lock_cnt <= '0;
      end else begin
         case (state)
            USER, PASS: begin
               if (press[4]) begin
                  if (state == USER) begin
                     state    <= PASS;
                     cursor_q <= '0;
                     leds_q   <= 4'b0001;
                  end else begin
                     state  <= CHECK;
                     leds_q <= 4'b0000;
                  end
               end else if (press[3]) begin
                  if (state == USER) user_q[sel_lsb +: 8] <= char_up(user_char);
                  else               pass_q[sel_lsb +: 8] <= char_up(pass_char);
               end else if (press[2]) begin
                  if (state == USER) user_q[sel_lsb +: 8] <= char_down(user_char);
                  else               pass_q[sel_lsb +: 8] <= char_down(pass_char);
               end else if (press[1]) begin
                  cursor_q <= cursor_q - 3'd1;
               end else if (press[0]) begin
                  cursor_q <= cursor_q + 3'd1;
               end
            end
            CHECK: begin
               if (bus.valid) begin
                  state  <= GRANTED;
                  fail_q <= '0;
                  leds_q <= 4'b0010;
               end else if ({1'b0, fail_q} + 5'd1 == 5'(MAX_FAILS)) begin
                  state    <= LOCKED;
                  fail_q   <= 4'(MAX_FAILS);
                  lock_cnt <= '0;
                  leds_q   <= 4'b1000;
               end else begin
                  state  <= DENIED;
                  fail_q <= fail_q + 4'd1;
                  leds_q <= 4'b0100;
               end
            end
            GRANTED: begin
               if (press[4]) begin
                  state    <= USER;
                  pass_q   <= BLANK;
                  cursor_q <= '0;
                  leds_q   <= 4'b0000;
               end
            end
            DENIED: begin
               if (press[4]) begin
                  state    <= PASS;
                  pass_q   <= BLANK;
                  cursor_q <= '0;
                  leds_q   <= 4'b0001;
               end
            end
            LOCKED: begin
               if (lock_cnt == LK_W'(LOCKOUT_CYCLES - 1)) begin
                  state    <= USER;
                  fail_q   <= '0;
                  pass_q   <= BLANK;
                  cursor_q <= '0;
                  leds_q   <= 4'b0000;
               end else begin
                  lock_cnt <= lock_cnt + LK_W'(1);
               end
            end
            default: begin
               state  <= USER;
               leds_q <= 4'b0000;
            end
         endcase
      end
   end

   assign bus.username   = user_q;
   assign bus.password   = pass_q;
   assign bus.cursor     = cursor_q;
   assign bus.fail_count = fail_q;
   assign bus.leds       = leds_q;

endmodule

// File: tb/tb_credential_entry.sv
// Bench for credential_entry: directed scenarios plus random button presses,
// checked against a cycle-aware behavioural model of the editor and lockout.
module tb_credential_entry;

   localparam int DEB  = 4;
   localparam int MAXF = 3;
   localparam int LOCK = 16;
   localparam logic [63:0] REF_USER = "ADMIN   ";
   localparam logic [63:0] REF_PASS = "PASSWORD";
   localparam logic [4:0] B_CENTER = 5'b10000;
   localparam logic [4:0] B_UP     = 5'b01000;
   localparam logic [4:0] B_DOWN   = 5'b00100;
   localparam logic [4:0] B_LEFT   = 5'b00010;
   localparam logic [4:0] B_RIGHT  = 5'b00001;
   localparam int M_USER = 0, M_PASS = 1, M_GRANT = 2, M_DENY = 3, M_LOCK = 4;

   logic   clk_100 = 1'b0;
   logic   rst_n;
   longint cycle = 0;
   int     checks = 0;
   int     failures = 0;

   int     m_user [8];
   int     m_pass [8];
   int     m_cur;
   int     m_fail;
   int     m_mode;
   longint unlock_edge;

   credential_entry_if bus ();

   credential_entry #(
      .DEBOUNCE_CYCLES(DEB),
      .MAX_FAILS(MAXF),
      .LOCKOUT_CYCLES(LOCK)
   ) dut (
      .clk_100(clk_100),
      .rst_n(rst_n),
      .bus(bus)
   );

   assign bus.valid = (bus.username == REF_USER) && (bus.password == REF_PASS);

   always #5 clk_100 = ~clk_100;
   always @(posedge clk_100) cycle <= cycle + 1;

   function automatic logic [63:0] pack(input int c [8]);
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[63-8*i -: 8] = 8'(c[i]);
      return v;
   endfunction

   function automatic logic [3:0] expLeds();
      case (m_mode)
         M_PASS:  return 4'b0001;
         M_GRANT: return 4'b0010;
         M_DENY:  return 4'b0100;
         M_LOCK:  return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h at cycle %0d", tag, got, exp, cycle);
      end
   endtask

   task automatic clearPass();
      for (int i = 0; i < 8; i++) m_pass[i] = 32;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 8; i++) m_user[i] = 32;
      clearPass();
      m_cur  = 0;
      m_fail = 0;
      m_mode = M_USER;
      unlock_edge = 0;
   endtask

   // The lockout ends on a fixed edge; anything observed after it sees USER.
   task automatic modelCatchup(input longint now);
      if (m_mode == M_LOCK && now >= unlock_edge) begin
         m_mode = M_USER;
         m_fail = 0;
         m_cur  = 0;
         clearPass();
      end
   endtask

   task automatic modelBump(input int d);
      if (m_mode == M_USER) m_user[m_cur] = 32 + (m_user[m_cur] - 32 + 95 + d) % 95;
      else                  m_pass[m_cur] = 32 + (m_pass[m_cur] - 32 + 95 + d) % 95;
   endtask

   task automatic modelAct(input logic [4:0] m, input longint a);
      modelCatchup(a - 1);
      case (m_mode)
         M_LOCK: ;
         M_GRANT: if (m[4]) begin m_mode = M_USER; clearPass(); m_cur = 0; end
         M_DENY:  if (m[4]) begin m_mode = M_PASS; clearPass(); m_cur = 0; end
         default: begin
            if (m[4]) begin
               if (m_mode == M_USER) begin
                  m_mode = M_PASS;
                  m_cur  = 0;
               end else if (pack(m_user) == REF_USER && pack(m_pass) == REF_PASS) begin
                  m_mode = M_GRANT;
                  m_fail = 0;
               end else if (m_fail + 1 == MAXF) begin
                  m_mode = M_LOCK;
                  m_fail = MAXF;
                  unlock_edge = a + 1 + LOCK;
               end else begin
                  m_mode = M_DENY;
                  m_fail = m_fail + 1;
               end
            end
            else if (m[3]) modelBump(1);
            else if (m[2]) modelBump(-1);
            else if (m[1]) m_cur = (m_cur + 7) % 8;
            else if (m[0]) m_cur = (m_cur + 1) % 8;
         end
      endcase
   endtask

   task automatic checkAll(input string tag);
      modelCatchup(cycle);
      checkOutput({tag, "/username"}, bus.username, pack(m_user));
      checkOutput({tag, "/password"}, bus.password, pack(m_pass));
      checkOutput({tag, "/cursor"}, 64'(bus.cursor), 64'(m_cur));
      checkOutput({tag, "/fail_count"}, 64'(bus.fail_count), 64'(m_fail));
      checkOutput({tag, "/leds"}, 64'(bus.leds), 64'(expLeds()));
   endtask

   task automatic driveButtons(input logic [4:0] m);
      {bus.center_button, bus.up_button, bus.down_button, bus.left_button, bus.right_button} = m;
   endtask

   // Called at a negedge with all buttons released; the debounced pulse acts on edge start+7.
   task automatic applyStimulus(input logic [4:0] m, input int hold, input bit midCheck, input string tag);
      longint start;
      start = cycle;
      driveButtons(m);
      modelAct(m, start + 2 + DEB + 1);
      repeat (hold) @(negedge clk_100);
      if (midCheck) checkAll(tag);
      driveButtons(5'b0);
      repeat (DEB + 3) @(negedge clk_100);
   endtask

   task automatic doReset(input int n);
      driveButtons(5'b0);
      rst_n = 1'b0;
      repeat (n) @(negedge clk_100);
      rst_n = 1'b1;
      modelReset();
   endtask

   task automatic typeString(input logic [63:0] s);
      int target, c, ups;
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 8 && m_cur != i; k++) applyStimulus(B_RIGHT, 8, 0, "");
         target = int'(s[63-8*i -: 8]);
         c = (m_mode == M_USER) ? m_user[m_cur] : m_pass[m_cur];
         ups = (target - c + 95) % 95;
         if (ups <= 47) repeat (ups) applyStimulus(B_UP, 8, 0, "");
         else           repeat (95 - ups) applyStimulus(B_DOWN, 8, 0, "");
      end
   endtask

   initial begin
      rst_n = 1'b0;
      driveButtons(5'b0);
      modelReset();
      @(negedge clk_100);
      doReset(2);
      checkAll("reset");

      // short glitch must not get through the debouncer
      bus.up_button = 1'b1;
      repeat (3) @(negedge clk_100);
      bus.up_button = 1'b0;
      repeat (10) @(negedge clk_100);
      checkAll("glitch");

      applyStimulus(B_UP, 20, 1, "held");
      checkAll("release");
      checkOutput("held_char0", 64'(bus.username[63:56]), 64'h21);

      doReset(2);
      repeat (95) applyStimulus(B_UP, 8, 0, "");
      checkAll("wrap_up");
      checkOutput("wrap_up_char0", 64'(bus.username[63:56]), 64'h20);
      applyStimulus(B_DOWN, 8, 1, "wrap_down");
      checkOutput("wrap_down_char0", 64'(bus.username[63:56]), 64'h7E);
      applyStimulus(B_LEFT, 8, 1, "cursor_wrap");
      checkOutput("cursor_wrap_val", 64'(bus.cursor), 64'd7);

      doReset(2);
      typeString(REF_USER);
      applyStimulus(B_CENTER, 8, 1, "to_pass");
      typeString(REF_PASS);
      applyStimulus(B_CENTER, 8, 1, "grant");
      checkOutput("grant_leds", 64'(bus.leds), 64'b0010);
      applyStimulus(B_CENTER, 8, 1, "grant_ack");

      applyStimulus(B_CENTER, 8, 1, "lock_pass");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(B_CENTER, 8, 1, "lock_submit");
         if (k < 2) applyStimulus(B_CENTER, 8, 1, "lock_retry");
      end
      checkOutput("locked_leds", 64'(bus.leds), 64'b1000);
      applyStimulus(B_UP | B_CENTER, 8, 1, "locked_ignore");
      repeat (10) @(negedge clk_100);
      checkAll("unlocked");

      applyStimulus(B_CENTER, 8, 1, "simul_pass");
      applyStimulus(B_UP | B_RIGHT, 8, 1, "simul");

      for (int k = 0; k < 3; k++) begin
         applyStimulus(B_CENTER, 8, 0, "");
         if (k < 2) applyStimulus(B_CENTER, 8, 0, "");
      end
      checkAll("relock");
      doReset(1);
      checkAll("reset_in_lock");

      repeat (60) begin
         applyStimulus(5'($urandom_range(1, 31)), 8, 0, "");
         checkAll("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
